// File: rtl/rv32i_mem_sequencer_pkg.sv
// Shared types for the rv32i memory sequencer: FSM state encoding and fault codes.
package rv32i_mem_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_DATA   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_FAULT  = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_IFETCH  = 2'b01,
    FC_DALIGN  = 2'b10,
    FC_TIMEOUT = 2'b11
  } fault_code_e;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/rv32i_mem_sequencer_if.sv
// Single-port memory request bus between the sequencer (master) and the memory model (slave).
interface rv32i_mem_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/rv32i_mem_sequencer_wait_timer.sv
// Request watchdog: down-counter reloaded while no request is pending, expiring on
// the LIMIT-th consecutive unanswered request cycle. LIMIT=0 never expires.
module rv32i_wait_timer #(
  parameter int unsigned LIMIT = 0
) (
  input  logic sys_clk,
  input  logic sys_reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [31:0] LOAD = 32'(LIMIT);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != 32'd0)) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (LOAD != 32'd0) && en_i && (cnt_q == 32'd1);

endmodule

// File: rtl/rv32i_mem_sequencer.sv
// Multi-cycle sequencer sharing one single-port memory between fetch and load/store;
// the core only advances on the one-cycle cpu_step strobe.
//
//   state  | meaning
//   IDLE   | paused at an instruction boundary while hold=1
//   FETCH  | instruction read at cpu_pc
//   EXEC   | core settles combinationally, data address checked
//   DATA   | load/store access at cpu_addr
//   COMMIT | cpu_step high, retired count advances
//   FAULT  | sticky until reset, no requests
module rv32i_mem_sequencer
  import rv32i_mem_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT   = 0,
  parameter logic [31:0] RETIRED_INIT = 32'h0000_0000
) (
  input  logic                   sys_clk,
  input  logic                   sys_reset,
  input  logic                   hold,
  input  logic [31:0]            cpu_pc,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic                   cpu_load,
  input  logic                   cpu_store,
  output logic [31:0]            instruction,
  output logic [31:0]            load_data,
  output logic                   cpu_step,
  output logic                   fault,
  output logic [1:0]             fault_code,
  output logic [31:0]            retired,
  rv32i_mem_sequencer_if.master  mem
);

  seq_state_e  state_q, state_d;
  fault_code_e fcode_q, fcode_d;
  logic [31:0] instr_q, load_q, retired_q;
  logic        fetch_ok, data_mem, tmo_clr, tmo_en, tmo_expired;
  logic        req_c, we_c, step_c;
  logic [31:0] addr_c, wdata_c;

  assign fetch_ok = word_aligned(cpu_pc);
  assign data_mem = cpu_load | cpu_store;
  assign tmo_clr  = (state_q != ST_FETCH) && (state_q != ST_DATA);
  assign tmo_en   = req_c & ~mem.mem_ready;

  rv32i_wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // mem_ready takes priority over a simultaneous timeout expiry
  always_comb begin
    state_d = state_q;
    fcode_d = fcode_q;
    case (state_q)
      ST_IDLE:   if (!hold) state_d = ST_FETCH;
      ST_FETCH: begin
        if (!fetch_ok) begin
          state_d = ST_FAULT;
          fcode_d = FC_IFETCH;
        end else if (mem.mem_ready) begin
          state_d = ST_EXEC;
        end else if (tmo_expired) begin
          state_d = ST_FAULT;
          fcode_d = FC_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (!data_mem) begin
          state_d = ST_COMMIT;
        end else if (!word_aligned(cpu_addr)) begin
          state_d = ST_FAULT;
          fcode_d = FC_DALIGN;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (mem.mem_ready) begin
          state_d = ST_COMMIT;
        end else if (tmo_expired) begin
          state_d = ST_FAULT;
          fcode_d = FC_TIMEOUT;
        end
      end
      ST_COMMIT: state_d = hold ? ST_IDLE : ST_FETCH;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = 32'h0;
    wdata_c = 32'h0;
    step_c  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req_c   = fetch_ok;
        addr_c  = cpu_pc;
        wdata_c = cpu_wdata;
      end
      ST_DATA: begin
        req_c   = 1'b1;
        we_c    = cpu_store;
        addr_c  = cpu_addr;
        wdata_c = cpu_wdata;
      end
      ST_COMMIT: step_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      instr_q   <= 32'h0;
      load_q    <= 32'h0;
      retired_q <= RETIRED_INIT;
      fcode_q   <= FC_NONE;
    end else begin
      fcode_q <= fcode_d;
      if ((state_q == ST_FETCH) && fetch_ok && mem.mem_ready) begin
        instr_q <= mem.mem_rdata;
      end
      if ((state_q == ST_DATA) && cpu_load && mem.mem_ready) begin
        load_q <= mem.mem_rdata;
      end
      if (state_q == ST_COMMIT) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;
  assign cpu_step      = step_c;
  assign instruction   = instr_q;
  assign load_data     = load_q;
  assign retired       = retired_q;
  assign fault         = (state_q == ST_FAULT);
  assign fault_code    = fcode_q;

endmodule

// File: tb/tb_rv32i_mem_sequencer.sv
// Self-checking bench for rv32i_mem_sequencer: the bench plays both core and memory,
// predicting latency, bus traffic and latched values from the instruction-level rules.
module tb_rv32i_mem_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        hold = 1'b1;
  logic        hold_w = 1'b0;
  logic [31:0] cpu_pc = 32'h0, cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        cpu_load = 1'b0, cpu_store = 1'b0;

  logic [31:0] instruction, load_data, retired;
  logic        cpu_step, fault;
  logic [1:0]  fault_code;
  logic [31:0] w_instruction, w_load_data, w_retired;
  logic        w_cpu_step, w_fault;
  logic [1:0]  w_fault_code;

  rv32i_mem_sequencer_if bus ();
  rv32i_mem_sequencer_if bus_w ();

  assign bus_w.mem_ready = 1'b1;
  assign bus_w.mem_rdata = 32'h0000_0013;

  always #5 sys_clk = ~sys_clk;

  rv32i_mem_sequencer #(.WAIT_LIMIT(4)) u_dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .hold(hold),
    .cpu_pc(cpu_pc), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_load(cpu_load), .cpu_store(cpu_store),
    .instruction(instruction), .load_data(load_data), .cpu_step(cpu_step),
    .fault(fault), .fault_code(fault_code), .retired(retired),
    .mem(bus.master)
  );

  rv32i_mem_sequencer #(.WAIT_LIMIT(0), .RETIRED_INIT(32'hFFFF_FFFF)) u_wrap (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .hold(hold_w),
    .cpu_pc(cpu_pc), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_load(cpu_load), .cpu_store(cpu_store),
    .instruction(w_instruction), .load_data(w_load_data), .cpu_step(w_cpu_step),
    .fault(w_fault), .fault_code(w_fault_code), .retired(w_retired),
    .mem(bus_w.master)
  );

  typedef struct {
    logic [31:0] pc, addr, wdata, iw, rd;
    logic        ld, st, hold_mid;
    int          wf, wd, lat;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned exp_retired;
  logic [31:0] exp_load;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, addr, wdata, iw, rd,
                              input logic ld, st, hm, input int wf, wd, lat);
    vec_t v;
    v.pc = pc; v.addr = addr; v.wdata = wdata; v.iw = iw; v.rd = rd;
    v.ld = ld; v.st = st; v.hold_mid = hm; v.wf = wf; v.wd = wd; v.lat = lat;
    return v;
  endfunction

  // Acts as core and memory for one instruction; returns one cycle after cpu_step.
  task automatic run_instr(input vec_t v);
    int   first, fcnt, dcnt, left;
    logic fetch_done, step_seen;
    cpu_pc = v.pc; cpu_addr = v.addr; cpu_wdata = v.wdata;
    cpu_load = v.ld; cpu_store = v.st;
    first = -1; fcnt = 0; dcnt = 0; left = v.wf; fetch_done = 1'b0; step_seen = 1'b0;
    #1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cpu_step) begin
        step_seen = 1'b1;
        chk("latency", 32'(cyc - first + 1), 32'(v.lat));
        chk("instruction", instruction, v.iw);
        if (v.ld) exp_load = v.rd;
        chk("load_data", load_data, exp_load);
        chk("fetch_req_cycles", 32'(fcnt), 32'(v.wf + 1));
        chk("data_req_cycles", 32'(dcnt), (v.ld || v.st) ? 32'(v.wd + 1) : 32'd0);
        chk("step_no_req", 32'(bus.mem_req), 32'd0);
        exp_retired++;
        bus.mem_ready = 1'b0;
        @(negedge sys_clk); #1;
        chk("step_one_cycle", 32'(cpu_step), 32'd0);
        chk("retired", retired, 32'(exp_retired));
        break;
      end
      if (bus.mem_req) begin
        if (first < 0) begin
          first = cyc;
          if (v.hold_mid) hold = 1'b1;
        end
        if (!fetch_done) begin
          fcnt++;
          chk("fetch_addr", bus.mem_addr, v.pc);
          chk("fetch_we", 32'(bus.mem_we), 32'd0);
        end else begin
          dcnt++;
          chk("data_addr", bus.mem_addr, v.addr);
          chk("data_we", 32'(bus.mem_we), 32'(v.st));
          if (v.st) chk("data_wdata", bus.mem_wdata, v.wdata);
        end
        if (left == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = fetch_done ? v.rd : v.iw;
          if (!fetch_done) begin
            fetch_done = 1'b1;
            left = v.wd;
          end
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
          left--;
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
      @(negedge sys_clk); #1;
    end
    chk("step_seen", 32'(step_seen), 32'd1);
  endtask

  task automatic run_fault(input int ncyc, input logic rdy, output int reqs, output int steps);
    reqs = 0; steps = 0;
    #1;
    for (int c = 0; c < ncyc; c++) begin
      if (bus.mem_req) begin
        reqs++;
        bus.mem_ready = rdy;
        bus.mem_rdata = 32'h0000_0013;
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (cpu_step) steps++;
      @(negedge sys_clk); #1;
    end
  endtask

  task automatic do_reset();
    sys_reset = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1;
    sys_reset = 1'b0;
    exp_retired = 0;
    exp_load = 32'h0;
  endtask

  initial begin
    int   reqs, steps;
    logic wseen, found;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    exp_retired = 0;
    exp_load = 32'h0;

    tbl[0] = mk(32'h0000_0000, 32'h0,         32'h0,         32'h0050_0093, 32'h0,         0, 0, 0, 0, 0, 3);
    tbl[1] = mk(32'h0000_0004, 32'h0000_0100, 32'h0,         32'h1000_2083, 32'hDEAD_BEEF, 1, 0, 0, 0, 2, 6);
    tbl[2] = mk(32'h0000_0008, 32'h0000_0104, 32'h1234_5678, 32'h1020_2223, 32'h0,         0, 1, 0, 0, 0, 4);
    tbl[3] = mk(32'h0000_000C, 32'h0000_0200, 32'h0,         32'h2000_2103, 32'hCAFE_F00D, 1, 0, 0, 3, 3, 10);
    tbl[4] = mk(32'h0000_0010, 32'h0,         32'h0,         32'h0000_0013, 32'h0,         0, 0, 0, 1, 0, 4);
    tbl[5] = mk(32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hA5A5_A5A5, 32'hFE20_2C23, 32'h0,         0, 1, 0, 2, 1, 7);

    repeat (2) @(negedge sys_clk);
    #1;
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_cpu_step", 32'(cpu_step), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_code", 32'(fault_code), 32'd0);
    chk("rst_retired", retired, 32'h0);
    chk("wrap_preset", w_retired, 32'hFFFF_FFFF);
    sys_reset = 1'b0;

    // hold=1 keeps the main instance idle while the preset instance wraps retired
    wseen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("idle_no_req", 32'(bus.mem_req), 32'd0);
      if (w_cpu_step) begin
        wseen = 1'b1;
        break;
      end
      @(negedge sys_clk); #1;
    end
    chk("wrap_step_seen", 32'(wseen), 32'd1);
    @(negedge sys_clk); #1;
    chk("retired_wrap", w_retired, 32'h0);
    hold = 1'b0;

    for (int i = 0; i < 6; i++) run_instr(tbl[i]);

    run_instr(mk(32'h0000_0020, 32'h0, 32'h0, 32'h0000_0013, 32'h0, 0, 0, 1, 2, 0, 5));
    for (int c = 0; c < 3; c++) begin
      chk("hold_idle_no_req", 32'(bus.mem_req), 32'd0);
      chk("hold_idle_no_step", 32'(cpu_step), 32'd0);
      @(negedge sys_clk); #1;
    end
    hold = 1'b0;
    run_instr(mk(32'h0000_0024, 32'h0000_0300, 32'h0, 32'h3000_2183, 32'h0BAD_F00D, 1, 0, 0, 0, 1, 5));

    for (int i = 0; i < 30; i++) begin
      vec_t v;
      int   k;
      k = $urandom_range(0, 2);
      v.pc = $urandom & 32'hFFFF_FFFC;
      v.addr = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.iw = $urandom;
      v.rd = $urandom;
      v.ld = (k == 1);
      v.st = (k == 2);
      v.hold_mid = 1'b0;
      v.wf = $urandom_range(0, 3);
      v.wd = $urandom_range(0, 3);
      v.lat = 3 + v.wf + ((v.ld || v.st) ? 1 + v.wd : 0);
      run_instr(v);
    end

    cpu_pc = 32'h0000_0002;
    cpu_load = 1'b0;
    cpu_store = 1'b0;
    run_fault(6, 1'b1, reqs, steps);
    chk("ifetch_reqs", 32'(reqs), 32'd0);
    chk("ifetch_steps", 32'(steps), 32'd0);
    chk("ifetch_fault", 32'(fault), 32'd1);
    chk("ifetch_code", 32'(fault_code), 32'd1);
    chk("ifetch_retired", retired, 32'(exp_retired));

    cpu_pc = 32'h0;
    cpu_addr = 32'h0000_0103;
    cpu_load = 1'b1;
    do_reset();
    chk("post_reset_fault", 32'(fault), 32'd0);
    run_fault(8, 1'b1, reqs, steps);
    chk("dalign_reqs", 32'(reqs), 32'd1);
    chk("dalign_steps", 32'(steps), 32'd0);
    chk("dalign_fault", 32'(fault), 32'd1);
    chk("dalign_code", 32'(fault_code), 32'd2);

    cpu_load = 1'b0;
    do_reset();
    run_fault(10, 1'b0, reqs, steps);
    chk("timeout_reqs", 32'(reqs), 32'd4);
    chk("timeout_steps", 32'(steps), 32'd0);
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_code", 32'(fault_code), 32'd3);

    cpu_pc = 32'h0000_0040;
    cpu_addr = 32'h0000_0300;
    cpu_wdata = 32'h5555_AAAA;
    cpu_store = 1'b1;
    do_reset();
    #1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.mem_req && bus.mem_we) begin
        found = 1'b1;
        bus.mem_ready = 1'b0;
        break;
      end
      bus.mem_ready = bus.mem_req;
      bus.mem_rdata = 32'h3000_A023;
      @(negedge sys_clk); #1;
    end
    chk("data_phase_reached", 32'(found), 32'd1);
    chk("pre_reset_instruction", instruction, 32'h3000_A023);
    sys_reset = 1'b1;
    #1;
    chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    chk("mid_rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("mid_rst_instruction", instruction, 32'h0);
    chk("mid_rst_load_data", load_data, 32'h0);
    chk("mid_rst_cpu_step", 32'(cpu_step), 32'd0);
    chk("mid_rst_fault", 32'(fault), 32'd0);
    chk("mid_rst_fault_code", 32'(fault_code), 32'd0);
    chk("mid_rst_retired", retired, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
